// File: rtl/instr_fetch_issue_if.sv
// Purpose: bundles the program-load, run-control and issue signals of instr_fetch_issue.
// Latency: none; this is plain wiring.
// Backpressure: hold travels from the datapath side toward the fetch stage.
interface instr_fetch_issue_if #(
  parameter int INSTR_WIDTH = 17,
  parameter int ADDR_WIDTH  = 6
);
  logic                   load_en;
  logic [ADDR_WIDTH-1:0]  load_addr;
  logic [INSTR_WIDTH-1:0] load_data;
  logic [ADDR_WIDTH:0]    prog_len;
  logic                   start;
  logic                   hold;
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   instr_valid;
  logic [ADDR_WIDTH:0]    pc;
  logic                   bubble;
  logic                   halted;

  // Controller / test side: drives loads and run control, observes the issue stream.
  modport master (
    output load_en, load_addr, load_data, prog_len, start, hold,
    input  instruction, instr_valid, pc, bubble, halted
  );

  // Fetch stage side.
  modport slave (
    input  load_en, load_addr, load_data, prog_len, start, hold,
    output instruction, instr_valid, pc, bubble, halted
  );
endinterface

// File: rtl/instr_fetch_issue.sv
// Purpose: program memory + PC walker issuing one registered instruction per cycle, with RAW bubbles.
// Latency: start at edge k, first valid instruction registered at edge k+1.
// Backpressure: hold freezes every register (outputs, PC, hazard history) while running.
module instr_fetch_issue #(
  parameter int                     INSTR_WIDTH  = 17,
  parameter int                     ADDR_WIDTH   = 6,
  parameter int                     HAZARD_DIST  = 2,
  parameter logic [INSTR_WIDTH-1:0] BUBBLE_INSTR = 17'h18000
) (
  input logic                clock,
  input logic                reset,
  instr_fetch_issue_if.slave bus
);
  localparam int                LEN_W   = ADDR_WIDTH + 1;
  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                 state_q, state_d;
  logic [LEN_W-1:0]       pc_q, pc_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   vld_q, vld_d;
  logic                   bub_q, bub_d;
  logic                   halted_q, halted_d;

  // Hazard history: entry 0 is the most recently issued slot.
  logic [HAZARD_DIST-1:0] hist_vld_q;
  logic [4:0]             hist_dst_q [HAZARD_DIST];
  logic                   hist_clr, hist_shift, push_vld;
  logic [4:0]             push_dst;

  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic [INSTR_WIDTH-1:0] fetch_word;
  logic [LEN_W-1:0]       len_sat;
  logic                   hazard;
  logic                   idle_like;

  assign idle_like  = (state_q != ST_RUN);
  assign fetch_word = mem[pc_q[ADDR_WIDTH-1:0]];
  assign len_sat    = (bus.prog_len > LEN_MAX) ? LEN_MAX : bus.prog_len;

  // Program memory write port; loads are only accepted while not running.
  always_ff @(posedge clock) begin
    if (bus.load_en && idle_like) mem[bus.load_addr] <= bus.load_data;
  end

  // RAW check of the word at pc against the recent destinations; opcode 11 is a no-op and never waits.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZARD_DIST; i++) begin
      if (hist_vld_q[i] &&
          (hist_dst_q[i] == fetch_word[9:5] || hist_dst_q[i] == fetch_word[4:0])) hazard = 1'b1;
    end
    if (fetch_word[16:15] == 2'b11) hazard = 1'b0;
  end

  // Run-control next state and next registered outputs.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    len_d      = len_q;
    instr_d    = instr_q;
    vld_d      = vld_q;
    bub_d      = bub_q;
    halted_d   = halted_q;
    hist_clr   = 1'b0;
    hist_shift = 1'b0;
    push_vld   = 1'b0;
    push_dst   = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        instr_d = BUBBLE_INSTR;
        vld_d   = 1'b0;
        bub_d   = 1'b0;
        if (bus.start) begin
          len_d    = len_sat;
          pc_d     = '0;
          hist_clr = 1'b1;
          // An empty program never enters RUN.
          if (len_sat == '0) begin
            state_d  = ST_DONE;
            halted_d = 1'b1;
          end else begin
            state_d  = ST_RUN;
            halted_d = 1'b0;
          end
        end
      end
      ST_RUN: begin
        if (!bus.hold) begin
          if (pc_q < len_q) begin
            hist_shift = 1'b1;
            if (hazard) begin
              instr_d = BUBBLE_INSTR;
              vld_d   = 1'b0;
              bub_d   = 1'b1;
            end else begin
              instr_d  = fetch_word;
              vld_d    = 1'b1;
              bub_d    = 1'b0;
              pc_d     = pc_q + LEN_W'(1);
              push_vld = (fetch_word[16:15] != 2'b11);
              push_dst = fetch_word[14:10];
            end
          end else begin
            instr_d  = BUBBLE_INSTR;
            vld_d    = 1'b0;
            bub_d    = 1'b0;
            state_d  = ST_DONE;
            halted_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset overrides hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      instr_q  <= BUBBLE_INSTR;
      vld_q    <= 1'b0;
      bub_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      instr_q  <= instr_d;
      vld_q    <= vld_d;
      bub_q    <= bub_d;
      halted_q <= halted_d;
    end
  end

  // Hazard history shift register; bubbles and opcode-11 words shift in "no destination".
  always_ff @(posedge clock) begin
    if (reset || hist_clr) begin
      hist_vld_q <= '0;
      for (int i = 0; i < HAZARD_DIST; i++) hist_dst_q[i] <= '0;
    end else if (hist_shift) begin
      for (int i = HAZARD_DIST - 1; i > 0; i--) begin
        hist_vld_q[i] <= hist_vld_q[i-1];
        hist_dst_q[i] <= hist_dst_q[i-1];
      end
      hist_vld_q[0] <= push_vld;
      hist_dst_q[0] <= push_dst;
    end
  end

  assign bus.instruction = instr_q;
  assign bus.instr_valid = vld_q;
  assign bus.pc          = pc_q;
  assign bus.bubble      = bub_q;
  assign bus.halted      = halted_q;
endmodule

// File: tb/tb_instr_fetch_issue.sv
// Purpose: directed plus randomized checking of instr_fetch_issue against an issue-slot schedule model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: hold is driven both at fixed slots and at random.
module tb_instr_fetch_issue;
  localparam int          HD  = 2;
  localparam logic [16:0] BUB = 17'h18000;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   nb, nb2;
  logic [16:0] tb_mem [64];

  instr_fetch_issue_if #(.INSTR_WIDTH(17), .ADDR_WIDTH(6)) bus ();

  instr_fetch_issue dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input int addr, input logic [16:0] w);
    bus.load_en   = 1'b1;
    bus.load_addr = 6'(addr);
    bus.load_data = w;
    tb_mem[addr]  = w;
    step();
    bus.load_en   = 1'b0;
  endtask

  task automatic chk_outs(input string tag, input logic [16:0] ins, input logic v,
                          input logic b, input logic [6:0] p, input logic h);
    chk({tag, "_instr"},  32'(bus.instruction), 32'(ins));
    chk({tag, "_valid"},  32'(bus.instr_valid), 32'(v));
    chk({tag, "_bubble"}, 32'(bus.bubble),      32'(b));
    chk({tag, "_pc"},     32'(bus.pc),          32'(p));
    chk({tag, "_halted"}, 32'(bus.halted),      32'(h));
  endtask

  // Model: instruction i issues in the first slot after its predecessor that is more than HD
  // slots after every earlier writer of one of its sources; the slot after the last word halts.
  // poke: 1 = load_en to addr 0 mid-run (must be ignored), 2 = start mid-run (must be ignored).
  task automatic run_prog(input int len_in, input int hold_pct, input int hold_slot,
                          input int hold_len, input int poke, input bit ld_start,
                          input logic [16:0] ld_word, output int nbub);
    int L, end_slot, s, cyc, held, issued;
    int slot [64];
    bit h, poked;
    logic [16:0] e_ins;
    logic        e_vld, e_bub, e_hlt;
    logic [6:0]  e_pc;
    L = (len_in > 64) ? 64 : len_in;
    if (ld_start) tb_mem[0] = ld_word;
    for (int i = 0; i < L; i++) begin
      slot[i] = (i == 0) ? 0 : slot[i-1] + 1;
      if (tb_mem[i][16:15] != 2'b11) begin
        for (int j = 0; j < i; j++) begin
          if (tb_mem[j][16:15] != 2'b11 &&
              (tb_mem[j][14:10] == tb_mem[i][9:5] || tb_mem[j][14:10] == tb_mem[i][4:0]) &&
              slot[j] + HD + 1 > slot[i]) slot[i] = slot[j] + HD + 1;
        end
      end
    end
    end_slot = (L == 0) ? 0 : slot[L-1] + 1;

    bus.prog_len = 7'(len_in);
    bus.start    = 1'b1;
    if (ld_start) begin
      bus.load_en   = 1'b1;
      bus.load_addr = 6'd0;
      bus.load_data = ld_word;
    end
    step();
    bus.start   = 1'b0;
    bus.load_en = 1'b0;
    e_ins = BUB; e_vld = 1'b0; e_bub = 1'b0; e_hlt = (L == 0); e_pc = 7'd0;
    chk_outs("start", e_ins, e_vld, e_bub, e_pc, e_hlt);

    s = 0; cyc = 0; held = 0; nbub = 0; issued = 0; poked = 1'b0;
    while (L > 0 && s <= end_slot && cyc < 1000) begin
      h = ((s == hold_slot) && (held < hold_len)) || ($urandom_range(99) < 32'(hold_pct));
      if (h && s == hold_slot) held++;
      if (poke != 0 && !poked && s == 1) begin
        h     = 1'b0;
        poked = 1'b1;
        if (poke == 1) begin
          bus.load_en   = 1'b1;
          bus.load_addr = 6'd0;
          bus.load_data = ~tb_mem[0];
        end else begin
          bus.start = 1'b1;
        end
      end
      bus.hold = h;
      step();
      bus.load_en = 1'b0;
      bus.start   = 1'b0;
      cyc++;
      if (!h) begin
        e_ins = BUB; e_vld = 1'b0; e_bub = 1'b0;
        if (s == end_slot) begin
          e_hlt = 1'b1;
          e_pc  = 7'(L);
        end else if (issued < L && slot[issued] == s) begin
          e_ins = tb_mem[issued];
          e_vld = 1'b1;
          issued++;
          e_pc  = 7'(issued);
        end else begin
          e_bub = 1'b1;
          nbub++;
        end
        s++;
      end
      chk_outs(h ? "held" : "run", e_ins, e_vld, e_bub, e_pc, e_hlt);
    end
    if (cyc >= 1000) chk("run_budget", 32'(cyc), 32'd0);
    bus.hold = 1'b0;
  endtask

  initial begin
    int n, len;
    reset = 1'b1;
    bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    bus.prog_len = '0;  bus.start = 1'b0;   bus.hold = 1'b0;

    // Reset then idle.
    step();
    chk_outs("reset1", BUB, 1'b0, 1'b0, 7'd0, 1'b0);
    step();
    chk_outs("reset2", BUB, 1'b0, 1'b0, 7'd0, 1'b0);
    reset = 1'b0;
    step();
    chk_outs("idle", BUB, 1'b0, 1'b0, 7'd0, 1'b0);

    // Independent stream.
    load_word(0, 17'b00_00100_00000_00001);
    load_word(1, 17'b01_00101_00001_00010);
    load_word(2, 17'b11_00000_00111_00100);
    run_prog(3, 0, -1, 0, 0, 1'b0, '0, nb);
    chk("indep_bubbles", 32'(nb), 32'd0);

    // Back-to-back dependency, then the same with a 3-cycle hold during the bubbles.
    load_word(1, 17'b10_00110_00100_00011);
    run_prog(2, 0, -1, 0, 0, 1'b0, '0, nb);
    chk("b2b_bubbles", 32'(nb), 32'd2);
    run_prog(2, 0, 2, 3, 0, 1'b0, '0, nb2);
    chk("b2b_hold_bubbles", 32'(nb2), 32'(nb));

    // Distance-2 dependency, then with a non-writing first word.
    load_word(1, 17'b01_00101_00001_00010);
    load_word(2, 17'b10_00111_00100_00000);
    run_prog(3, 0, -1, 0, 0, 1'b0, '0, nb);
    chk("dist2_bubbles", 32'(nb), 32'd1);
    load_word(0, 17'b11_00100_00000_00001);
    run_prog(3, 0, -1, 0, 0, 1'b0, '0, nb);
    chk("dist2_nodst_bubbles", 32'(nb), 32'd0);

    // Empty program.
    run_prog(0, 0, -1, 0, 0, 1'b0, '0, nb);
    step();
    chk_outs("len0_a", BUB, 1'b0, 1'b0, 7'd0, 1'b1);
    step();
    chk_outs("len0_b", BUB, 1'b0, 1'b0, 7'd0, 1'b1);

    // Load during RUN is ignored; start during RUN is ignored.
    load_word(3, 17'b00_01000_01001_01010);
    run_prog(4, 0, -1, 0, 1, 1'b0, '0, nb);
    run_prog(4, 0, -1, 0, 0, 1'b0, '0, nb);
    run_prog(4, 0, -1, 0, 2, 1'b0, '0, nb);

    // Simultaneous load and start from DONE fetches the new word.
    run_prog(4, 0, -1, 0, 0, 1'b1, 17'b01_00010_00100_00101, nb);

    // Reset mid-RUN, with hold asserted at the same time.
    bus.prog_len = 7'd4;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    reset = 1'b1;
    bus.hold = 1'b1;
    step();
    chk_outs("midrun_reset", BUB, 1'b0, 1'b0, 7'd0, 1'b0);
    reset = 1'b0;
    bus.hold = 1'b0;
    step();
    chk_outs("after_reset", BUB, 1'b0, 1'b0, 7'd0, 1'b0);

    // Full memory with an oversized prog_len saturates at 64 words.
    for (int i = 0; i < 64; i++)
      load_word(i, {2'($urandom_range(3)), 3'b000, 2'($urandom_range(3)), 3'b000,
                    2'($urandom_range(3)), 3'b000, 2'($urandom_range(3))});
    run_prog(127, 10, -1, 0, 0, 1'b0, '0, nb);

    // Randomized programs with narrow register fields to provoke hazards, random hold.
    for (int t = 0; t < 15; t++) begin
      n = int'($urandom_range(1, 16));
      for (int i = 0; i < n; i++)
        load_word(i, {2'($urandom_range(3)), 3'b000, 2'($urandom_range(3)), 3'b000,
                      2'($urandom_range(3)), 3'b000, 2'($urandom_range(3))});
      len = int'($urandom_range(0, n));
      run_prog(len, 25, -1, 0, 0, 1'b0, '0, nb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_issue.md
Name: instr_fetch_issue

Overview:
- Front-end stage feeding the 17-bit `instruction` input of the JericallaEvo datapath.
- Holds a loadable program memory and walks it with a program counter under a small run-control FSM.
- Issues one registered instruction per cycle.
- Inserts bubbles on read-after-write hazards against the two-stage downstream pipeline, so a dependent instruction never reads a register before the producing instruction has written back.

Parameters:
- INSTR_WIDTH, 17, instruction width: opcode[16:15], write addr[14:10], read addr1[9:5], read addr2[4:0].
- ADDR_WIDTH, 6, program memory address width; depth = 2**ADDR_WIDTH.
- HAZARD_DIST, 2, number of previously issued instructions checked for RAW conflict (1..4).
- BUBBLE_INSTR, 17'h18000, word driven on bubble and idle cycles (opcode 11, all fields 0).

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high.
- load_en  input  1  program write strobe; honoured only in IDLE or DONE.
- load_addr  input  ADDR_WIDTH  program write address.
- load_data  input  INSTR_WIDTH  program write data.
- prog_len  input  ADDR_WIDTH+1  number of instructions to issue; sampled when start is accepted.
- start  input  1  begin issuing from PC 0; honoured only in IDLE or DONE.
- hold  input  1  downstream freeze; holds outputs, PC and hazard history.
- instruction  output  INSTR_WIDTH  registered instruction to the datapath.
- instr_valid  output  1  instruction is a real program word, not a bubble.
- pc  output  ADDR_WIDTH+1  address of the next word to fetch.
- bubble  output  1  registered; high for the cycle a hazard bubble is issued.
- halted  output  1  high in DONE.

Behaviour:
- Reset values:
  - instruction = BUBBLE_INSTR; instr_valid = 0; bubble = 0; pc = 0; halted = 0; state = IDLE.
  - Hazard history cleared to "no destination".
  - Program memory contents are not cleared.
- Program memory:
  - Write: one word per cycle on load_en in IDLE/DONE.
  - Read: combinational from pc[ADDR_WIDTH-1:0].
  - A load_en in RUN is ignored.
- Writing instruction: opcode 00, 01 or 10. Its destination is bits[14:10]. Opcode 11 has no destination.
- Hazard:
  - The word at pc conflicts if read addr1 or read addr2 equals the destination of any of the last HAZARD_DIST history entries.
  - Only real writing instructions push a destination. Bubbles and opcode-11 instructions push "none".
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Outputs show the BUBBLE_INSTR word with instr_valid = 0.
  - start at edge k → RUN, pc = 0, prog_len latched, history cleared.
  - If the latched prog_len = 0, go straight to DONE instead; no word is issued.
- RUN, hold = 1: all registers hold, including the history. Outputs are stable.
- RUN, hold = 0, pc < len, no hazard:
  - instruction <= mem[pc]; instr_valid <= 1; bubble <= 0; pc <= pc+1.
  - History shifts in this word's destination, or "none" for opcode 11.
- RUN, hold = 0, pc < len, hazard:
  - instruction <= BUBBLE_INSTR; instr_valid <= 0; bubble <= 1; pc holds.
  - History shifts in "none".
- RUN, hold = 0, pc == len:
  - instruction <= BUBBLE_INSTR; instr_valid <= 0; bubble <= 0.
  - State → DONE, halted <= 1.
- Latency: start at edge k → first valid instruction registered at edge k+1.
- Throughput: one word per non-held cycle. A dependency on the immediately preceding word costs exactly HAZARD_DIST bubbles; a dependency two back costs HAZARD_DIST−1.
- DONE:
  - halted stays 1; outputs show the bubble word with instr_valid = 0.
  - start restarts exactly as from IDLE, and halted clears at the same edge.
- Simultaneous load_en and start in IDLE/DONE: the write completes, and the restart fetches the updated contents.
- reset asserted in any state, including mid-RUN or during hold: returns to the reset values at the next edge; reset has priority over hold.
- pc never wraps: prog_len saturates at 2**ADDR_WIDTH.

Test Plan:
- Reset then idle: reset 2 cycles with start = 0 → instruction = 17'h18000, instr_valid = 0, pc = 0, halted = 0 every cycle.
- Independent stream:
  - Stimulus: load mem[0]=00_00100_00000_00001, mem[1]=01_00101_00001_00010, mem[2]=11_00000_00111_00100; prog_len = 3; start.
  - Required: three consecutive valid words with no bubble, then halted = 1 one cycle after the last word.
- Back-to-back dependency: mem[0]=00_00100_00000_00001, mem[1]=10_00110_00100_00011, prog_len = 2 → word 0, two bubble cycles (bubble = 1, pc = 1), then word 1 valid.
- Distance-2 dependency: mem[0] writes r4, mem[1]=01_00101_00001_00010, mem[2] reads r4 → exactly one bubble before mem[2]. Repeat with mem[0] opcode 11 → no bubble.
- Hold mid-run: assert hold for 3 cycles during a hazard bubble → instruction, pc and bubble frozen; the bubble count after release matches the no-hold case.
- Corner cases:
  - prog_len = 0 with start → DONE next cycle; instr_valid is never asserted.
  - load_en during RUN → the memory word is unchanged when the program is reissued.
  - reset mid-RUN → outputs return to reset values at the next edge.
  - start during RUN → ignored; no restart occurs.
